gemm_ctrl: RTL and testbench

Sequencer that drives the 8-entry multiply-accumulate core from the host side. It loads weight words into the core's matrix, streams an input vector through it, and returns the dot product over a valid/ready result port. It sits between the DPI/host stream interfaces and the core, and absorbs the core's fixed two-stage exec pipeline so that host streams may stall arbitrarily.

---
 rtl/gemm_pkg.sv | 28 ++
 rtl/gemm_ctrl.sv | 145 ++++++++++++++
 tb/tb_gemm_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_pkg.sv
// Shared constants and types for the GEMM host-side sequencer.
package gemm_pkg;

    localparam int DEPTH    = 8;
    localparam int AW       = $clog2(DEPTH);
    localparam int DW       = 32;
    localparam int LW       = 4;
    // Cycles from the last exec until acc holds the final sum and may be sampled.
    localparam int EXEC_LAT = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_OUT
    } state_e;

    // Requested lengths beyond the matrix size are limited to the matrix size.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
        if (len > LW'(DEPTH)) begin
            return LW'(DEPTH);
        end
        return len;
    endfunction

endpackage

// File: rtl/gemm_ctrl.sv
// Host-side sequencer for the multiply-accumulate core: loads weights,
// streams an input vector through the core's exec pipeline and returns
// the accumulated dot product over a valid/ready result port.
module gemm_ctrl
    import gemm_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [LW-1:0] cmd_len,
    input  logic          w_valid,
    output logic          w_ready,
    input  logic [DW-1:0] w_data,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic [DW-1:0] x_data,
    output logic          r_valid,
    input  logic          r_ready,
    output logic [DW-1:0] r_data,
    output logic          init,
    output logic          write,
    output logic          exec,
    output logic [AW-1:0] ra,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] d,
    output logic [DW-1:0] wd,
    input  logic [DW-1:0] acc
);

    localparam logic [1:0] DRAIN_LAST = 2'(EXEC_LAT - 1);

    state_e        state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [DW-1:0] d_q, d_d;
    logic [1:0]    drn_q, drn_d;
    logic [DW-1:0] res_q, res_d;

    // State and datapath registers; reset abandons any command in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            d_q     <= '0;
            drn_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            d_q     <= d_d;
            drn_q   <= drn_d;
            res_q   <= res_d;
        end
    end

    // Next-state logic and core/host strobes; write and exec are decoded
    // from mutually exclusive states, and init only exists in CLEAR.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        d_d       = d_q;
        drn_d     = drn_q;
        res_d     = res_q;

        cmd_ready = (state_q == S_IDLE);
        w_ready   = (state_q == S_LOAD) && (cnt_q < len_q);
        x_ready   = (state_q == S_RUN) && (cnt_q < len_q);
        write     = w_valid & w_ready;
        exec      = x_valid & x_ready;
        init      = (state_q == S_CLEAR);
        r_valid   = (state_q == S_OUT);
        r_data    = res_q;
        d         = d_q;
        wa        = '0;
        wd        = '0;
        ra        = '0;

        if (write) begin
            wa = cnt_q[AW-1:0];
            wd = w_data;
        end
        if (exec) begin
            ra = cnt_q[AW-1:0];
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    len_d = clamp_len(cmd_len);
                    cnt_d = '0;
                    if (cmd_op) begin
                        state_d = S_CLEAR;
                    end else if (clamp_len(cmd_len) != '0) begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (write) begin
                    cnt_d = cnt_q + LW'(1);
                    if (cnt_d == len_q) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_CLEAR: begin
                drn_d   = '0;
                state_d = (len_q == '0) ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                if (exec) begin
                    // The core samples d one cycle after exec, so hold the beat here.
                    d_d   = x_data;
                    cnt_d = cnt_q + LW'(1);
                    if (cnt_d == len_q) begin
                        drn_d   = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drn_q == DRAIN_LAST) begin
                    res_d   = acc;
                    state_d = S_OUT;
                end else begin
                    drn_d = drn_q + 2'd1;
                end
            end
            S_OUT: begin
                if (r_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gemm_ctrl.sv
// Bench for gemm_ctrl: a behavioural MAC core model drives acc, and each
// result is compared with a dot product computed from the weights and
// vectors the bench has sent.
module tb_gemm_ctrl;
    import gemm_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_op;
    logic [LW-1:0] cmd_len;
    logic          w_valid, w_ready;
    logic [DW-1:0] w_data;
    logic          x_valid, x_ready;
    logic [DW-1:0] x_data;
    logic          r_valid, r_ready;
    logic [DW-1:0] r_data;
    logic          init, write, exec;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] d, wd;
    logic [DW-1:0] acc = '0;

    gemm_ctrl dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .init(init), .write(write), .exec(exec),
        .ra(ra), .wa(wa), .d(d), .wd(wd), .acc(acc)
    );

    always #5 clk = ~clk;

    // Core model: exec at t reads mem[ra] and d at t+1, acc updates at end of t+2;
    // init at t clears acc at end of t+2.
    logic [DW-1:0] mem [DEPTH];
    logic          c1_exec = 1'b0, c1_init = 1'b0, c2_exec = 1'b0, c2_init = 1'b0;
    logic [AW-1:0] c1_ra = '0;
    logic [DW-1:0] c2_prod = '0;
    always @(posedge clk) begin
        c1_exec <= exec;
        c1_init <= init;
        c1_ra   <= ra;
        c2_exec <= c1_exec;
        c2_init <= c1_init;
        c2_prod <= mem[c1_ra] * d;
        if (c2_init) acc <= '0;
        else if (c2_exec) acc <= acc + c2_prod;
        if (write) mem[wa] <= wd;
    end

    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_RUN = 2;

    int checks = 0, errors = 0;
    int cyc_n = 0, acc_cyc = 0, last_lat = 0;
    int n_init = 0, n_exec = 0;
    int phase = PH_IDLE, exp_len = 0, w_idx = 0, x_idx = 0;
    logic          prev_exec = 1'b0;
    logic [DW-1:0] prev_x = '0;
    logic [DW-1:0] last_res = '0;
    logic [DW-1:0] wref [DEPTH];
    logic [DW-1:0] wq [DEPTH];
    logic [DW-1:0] xq [DEPTH];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] dot(input int n);
        logic [DW-1:0] s;
        s = '0;
        for (int i = 0; i < n; i++) s = s + wref[i] * xq[i];
        return s;
    endfunction

    // One clock cycle: check strobes mid-cycle, track handshakes, advance to edge+1.
    task automatic cyc();
        logic ewr, exr;
        #3;
        ewr = (phase == PH_LOAD) && (w_idx < exp_len);
        exr = (phase == PH_RUN) && (x_idx < exp_len);
        chk("w_ready", DW'(w_ready), DW'(ewr));
        chk("x_ready", DW'(x_ready), DW'(exr));
        chk("write", DW'(write), DW'(w_valid & ewr));
        chk("exec", DW'(exec), DW'(x_valid & exr));
        chk("exec_init_excl", DW'(exec & init), '0);
        if (w_valid && ewr) begin
            chk("wa", DW'(wa), DW'(w_idx));
            chk("wd", wd, w_data);
        end
        if (x_valid && exr) chk("ra", DW'(ra), DW'(x_idx));
        if (prev_exec) chk("d", d, prev_x);
        if (init) n_init++;
        if (exec) n_exec++;
        prev_exec = x_valid && exr;
        prev_x    = x_data;
        if (phase == PH_LOAD && w_valid && w_ready) begin
            w_idx++;
            if (w_idx >= exp_len) phase = PH_IDLE;
        end
        if (phase == PH_RUN && x_valid && x_ready) begin
            x_idx++;
            if (x_idx >= exp_len) phase = PH_IDLE;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic check_reset_outputs();
        chk("rst_cmd_ready", DW'(cmd_ready), 1);
        chk("rst_w_ready", DW'(w_ready), 0);
        chk("rst_x_ready", DW'(x_ready), 0);
        chk("rst_r_valid", DW'(r_valid), 0);
        chk("rst_init", DW'(init), 0);
        chk("rst_write", DW'(write), 0);
        chk("rst_exec", DW'(exec), 0);
        chk("rst_ra", DW'(ra), 0);
        chk("rst_wa", DW'(wa), 0);
        chk("rst_d", d, 0);
        chk("rst_wd", wd, 0);
        chk("rst_r_data", r_data, 0);
    endtask

    task automatic send_cmd(input logic op, input logic [LW-1:0] len);
        int t;
        t = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        while (!cmd_ready && t < 50) begin
            cyc();
            t++;
        end
        chk("cmd_ready_wait", DW'(cmd_ready), 1);
        acc_cyc = cyc_n;
        exp_len = (int'(len) > DEPTH) ? DEPTH : int'(len);
        w_idx = 0;
        x_idx = 0;
        cyc();
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_len   = '0;
        chk("cmd_ready_busy", DW'(cmd_ready), DW'(op == 1'b0 && exp_len == 0));
        if (op == 1'b0) begin
            phase = (exp_len > 0) ? PH_LOAD : PH_IDLE;
        end else begin
            chk("init_clear", DW'(init), 1);
            cyc();
            chk("init_once", DW'(init), 0);
            phase = (exp_len > 0) ? PH_RUN : PH_IDLE;
        end
    endtask

    task automatic do_load(input logic [LW-1:0] len, input logic stall);
        int g;
        g = 0;
        send_cmd(1'b0, len);
        while (w_idx < exp_len && g < 200) begin
            w_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            w_data  = wq[w_idx];
            cyc();
            g++;
        end
        w_valid = 1'b0;
        w_data  = '0;
        chk("load_beats", DW'(w_idx), DW'(exp_len));
        for (int i = 0; i < exp_len; i++) wref[i] = wq[i];
        chk("load_idle", DW'(cmd_ready), 1);
    endtask

    // mode 0: no stalls, 1: x_valid low every other cycle, 2: random stalls.
    task automatic do_run(input logic [LW-1:0] len, input int mode, input int hold);
        int g, k;
        logic [DW-1:0] expv;
        g = 0;
        k = 0;
        send_cmd(1'b1, len);
        while (x_idx < exp_len && g < 200) begin
            x_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(k % 2 == 0) : 1'($urandom_range(0, 1));
            x_data  = xq[x_idx];
            cyc();
            g++;
            k++;
        end
        x_valid = 1'b0;
        x_data  = '0;
        chk("run_beats", DW'(x_idx), DW'(exp_len));
        expv = dot(exp_len);
        g = 0;
        while (!r_valid && g < 20) begin
            cyc();
            g++;
        end
        chk("r_valid", DW'(r_valid), 1);
        last_lat = cyc_n - acc_cyc + 1;
        if (mode == 0) chk("latency", DW'(last_lat), DW'(exp_len + 6));
        chk("r_data", r_data, expv);
        last_res = r_data;
        for (int h = 0; h < hold; h++) begin
            cyc();
            chk("hold_valid", DW'(r_valid), 1);
            chk("hold_data", r_data, expv);
            chk("hold_cmd_ready", DW'(cmd_ready), 0);
        end
        r_ready = 1'b1;
        cyc();
        r_ready = 1'b0;
        chk("post_r_valid", DW'(r_valid), 0);
        chk("post_cmd_ready", DW'(cmd_ready), 1);
    endtask

    initial begin
        int s_init, s_exec, rlen, rmode, rhold;
        logic [LW-1:0] llen;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_len = '0;
        w_valid = 1'b0; w_data = '0;
        x_valid = 1'b0; x_data = '0;
        r_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) wref[i] = '0;
        @(posedge clk);
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs();

        // Directed: 1..8 . 1..8 = 204, minimum latency
        for (int i = 0; i < DEPTH; i++) begin
            wq[i] = DW'(i + 1);
            xq[i] = DW'(i + 1);
        end
        do_load(4'd8, 1'b0);
        do_run(4'd8, 0, 0);
        chk("dot204", last_res, 32'd204);
        chk("lat14", DW'(last_lat), 32'd14);

        // Same vector with x_valid low every other cycle
        do_run(4'd8, 1, 0);
        chk("dot204_bubbles", last_res, 32'd204);

        // Zero-length run: one init, no exec, result 0
        s_init = n_init;
        s_exec = n_exec;
        do_run(4'd0, 0, 0);
        chk("len0_result", last_res, 32'd0);
        chk("len0_init_pulses", DW'(n_init - s_init), 32'd1);
        chk("len0_exec_pulses", DW'(n_exec - s_exec), 32'd0);

        // Wrap modulo 2^32, with result back-pressure
        for (int i = 0; i < DEPTH; i++) begin
            wq[i] = 32'hFFFF_FFFF;
            xq[i] = 32'd2;
        end
        do_load(4'd3, 1'b1);
        do_run(4'd3, 0, 5);
        chk("wrap_result", last_res, 32'hFFFF_FFFA);

        // Randomized loads and runs, including clamped lengths and stalls
        for (int it = 0; it < 10; it++) begin
            llen = 4'($urandom_range(0, 15));
            for (int i = 0; i < DEPTH; i++) wq[i] = $urandom;
            do_load(llen, 1'($urandom_range(0, 1)));
            rlen  = $urandom_range(0, 15);
            rmode = $urandom_range(0, 2);
            rhold = $urandom_range(0, 3);
            for (int i = 0; i < DEPTH; i++) xq[i] = $urandom;
            do_run(4'(rlen), rmode, rhold);
        end

        // Reset in the middle of a run after four beats
        for (int i = 0; i < DEPTH; i++) begin
            wq[i] = DW'(i + 1);
            xq[i] = DW'(i + 1);
        end
        do_load(4'd8, 1'b0);
        send_cmd(1'b1, 4'd8);
        begin
            int g;
            g = 0;
            while (x_idx < 4 && g < 50) begin
                x_valid = 1'b1;
                x_data  = xq[x_idx];
                cyc();
                g++;
            end
        end
        x_valid = 1'b0;
        x_data  = '0;
        chk("pre_reset_beats", DW'(x_idx), 32'd4);
        reset = 1'b1;
        #2;
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        phase     = PH_IDLE;
        prev_exec = 1'b0;
        check_reset_outputs();
        for (int i = 0; i < 3; i++) cyc();
        do_run(4'd8, 0, 0);
        chk("dot204_after_reset", last_res, 32'd204);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
